// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

   // Defaults shared with the 8x8 sync FIFO and the bench
   localparam int unsigned DEF_DATA_W       = 8;
   localparam int unsigned DEF_CLKS_PER_BIT = 16;
   localparam int unsigned FIFO_DEPTH       = 8;

   // Transmitter FSM states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } state_t;

   // Bits on the wire per frame: start + data + optional parity + stop
   function automatic int unsigned frame_bits(input int unsigned data_w,
                                              input int unsigned parity_en);
      return 2 + data_w + ((parity_en != 0) ? 1 : 0);
   endfunction

   // Clock cycles per frame on the tx line
   function automatic int unsigned frame_cycles(input int unsigned data_w,
                                                input int unsigned parity_en,
                                                input int unsigned clks_per_bit);
      return frame_bits(data_w, parity_en) * clks_per_bit;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, with a tick on
// the last cycle of each bit and a pre-tick one cycle earlier.
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick,
   output logic pre_tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   // Free-running bit counter, held at zero by clear and wrapping at LAST
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + ONE;
      end
   end

   assign tick     = (cnt == LAST);
   assign pre_tick = (cnt == PRE_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte per frame from a sync FIFO
// and sends start, DATA_W data bits LSB-first, optional even parity, stop.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned PARITY_EN    = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] rd_data,
   output logic              rd_enb,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

   state_t            state;
   logic [DATA_W-1:0] shift;
   logic [DATA_W-1:0] next_shift;
   logic [BIT_W-1:0]  bit_cnt;
   logic              parity;
   logic              tick;
   logic              pre_tick;
   logic              baud_clear;
   logic              can_fetch;

   assign next_shift = shift >> 1;
   assign can_fetch  = enable && !fifo_empty;

   // Serial states change only on tick, where the counter wraps to zero on its
   // own, so an explicit clear is only needed outside the serial states.
   assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (baud_clear),
      .tick    (tick),
      .pre_tick(pre_tick)
   );

   // Frame FSM; tx is loaded on the edge entering each state so the line
   // level always matches the current state with no combinational path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tx         <= 1'b1;
         rd_enb     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         bit_cnt    <= '0;
         shift      <= '0;
         parity     <= 1'b0;
      end else begin
         rd_enb     <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (can_fetch) begin
                  state  <= FETCH;
                  rd_enb <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            FETCH: begin
               state <= LOAD;
            end
            LOAD: begin
               shift   <= rd_data;
               parity  <= ^rd_data;
               bit_cnt <= '0;
               tx      <= 1'b0;
               state   <= START;
            end
            START: begin
               if (tick) begin
                  tx    <= shift[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  shift <= next_shift;
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        tx    <= parity;
                        state <= PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BIT_ONE;
                     tx      <= next_shift[0];
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  tx    <= 1'b1;
                  state <= STOP;
               end
            end
            STOP: begin
               // frame_done is registered, so it is raised one cycle early
               if (pre_tick) begin
                  frame_done <= 1'b1;
               end
               if (tick) begin
                  if (can_fetch) begin
                     state  <= FETCH;
                     rd_enb <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: channel 0 without parity, channel 1
// with even parity, each fed by a small behavioural 8-deep FIFO.
module tb_fifo_uart_tx;

   localparam int unsigned CPB = 4;
   localparam int unsigned DW  = 8;

   typedef struct packed {
      logic [7:0] data;
      logic       par;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0]      enable;
   logic [1:0]      fifo_empty;
   logic [1:0][7:0] rd_data = '0;
   logic [1:0]      rd_enb;
   logic [1:0]      tx_v;
   logic [1:0]      busy;
   logic [1:0]      frame_done;

   logic [1:0]      wr_en;
   logic [1:0][7:0] wr_data;
   logic [7:0]      mem [2][8];
   int unsigned     wp [2] = '{0, 0};
   int unsigned     rp [2] = '{0, 0};
   int unsigned     cnt [2] = '{0, 0};
   logic [1:0]      underrun = '0;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int last_rd [2]     = '{-100, -100};
   int last_end [2]    = '{-100, -100};
   int rd_pulses [2]   = '{0, 0};
   int frames_seen [2] = '{0, 0};
   logic [1:0] prev_rd = '0;
   logic [1:0] b2b_check;

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable[0]), .fifo_empty(fifo_empty[0]),
      .rd_data(rd_data[0]), .rd_enb(rd_enb[0]), .tx(tx_v[0]), .busy(busy[0]),
      .frame_done(frame_done[0]));

   fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut_p (
      .clk(clk), .rst_n(rst_n), .enable(enable[1]), .fifo_empty(fifo_empty[1]),
      .rd_data(rd_data[1]), .rd_enb(rd_enb[1]), .tx(tx_v[1]), .busy(busy[1]),
      .frame_done(frame_done[1]));

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Behavioural FIFO: registered read data, not reset with the DUT
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int c = 0; c < 2; c++) begin
         if (rd_enb[c]) begin
            if (cnt[c] == 0) underrun[c] <= 1'b1;
            else begin
               rd_data[c] <= mem[c][rp[c]];
               rp[c] <= (rp[c] + 1) % 8;
            end
         end
         if (wr_en[c]) begin
            mem[c][wp[c]] <= wr_data[c];
            wp[c] <= (wp[c] + 1) % 8;
         end
         cnt[c] <= cnt[c] + (wr_en[c] ? 1 : 0) - ((rd_enb[c] && cnt[c] != 0) ? 1 : 0);
      end
   end

   always_comb begin
      fifo_empty[0] = (cnt[0] == 0);
      fifo_empty[1] = (cnt[1] == 0);
   end

   // Read-strobe guard: never on an empty FIFO, never two cycles running
   always @(negedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (rd_enb[c]) begin
            check($sformatf("ch%0d_rd_enb_guard", c), {62'd0, fifo_empty[c], prev_rd[c]}, 64'd0);
            last_rd[c] = cyc;
            rd_pulses[c]++;
         end
         prev_rd[c] = rd_enb[c];
      end
   end

   function automatic bit pop_exp(input int ch, output exp_t e);
      e = '0;
      if (ch == 0) begin
         if (q0.size() == 0) return 1'b0;
         e = q0.pop_front();
      end else begin
         if (q1.size() == 0) return 1'b0;
         e = q1.pop_front();
      end
      return 1'b1;
   endfunction

   task automatic monitor(input int ch);
      int unsigned ncyc;
      logic [63:0] cap, fdv, expc;
      logic [10:0] fv;
      exp_t e;
      bit armed, aborted, ok;
      int start;
      ncyc = ((ch == 1) ? 11 : 10) * CPB;
      armed = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && !tx_v[ch]) begin
            start = cyc;
            // rd_enb cycle, LOAD cycle, then start bit: third cycle
            check($sformatf("ch%0d_rd_to_start", ch), 64'(start - last_rd[ch]), 64'd2);
            if (armed && b2b_check[ch])
               check($sformatf("ch%0d_b2b_gap", ch), 64'(start - last_end[ch]), 64'd3);
            cap = '0; fdv = '0; aborted = 1'b0;
            cap[0] = tx_v[ch];
            fdv[0] = frame_done[ch];
            for (int unsigned i = 1; i < ncyc; i++) begin
               @(negedge clk);
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               cap[i] = tx_v[ch];
               fdv[i] = frame_done[ch];
            end
            if (aborted) begin
               armed = 1'b0;
            end else begin
               ok = pop_exp(ch, e);
               check($sformatf("ch%0d_expect_pending", ch), {63'd0, ok}, 64'd1);
               if (ch == 1) fv = {1'b1, e.par, e.data, 1'b0};
               else         fv = {2'b11, e.data, 1'b0};
               expc = '0;
               for (int unsigned i = 0; i < ncyc; i++) expc[i] = fv[i / CPB];
               check($sformatf("ch%0d_frame_%02h", ch, e.data), cap, expc);
               check($sformatf("ch%0d_frame_done_%02h", ch, e.data), fdv, 64'd1 << (ncyc - 1));
               last_end[ch] = cyc;
               armed = b2b_check[ch];
               frames_seen[ch]++;
            end
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   task automatic push(input int ch, input logic [7:0] d, input logic p);
      exp_t e;
      e.data = d;
      e.par  = p;
      @(negedge clk);
      wr_en[ch]   = 1'b1;
      wr_data[ch] = d;
      if (ch == 0) q0.push_back(e);
      else         q1.push_back(e);
      @(negedge clk);
      wr_en[ch] = 1'b0;
   endtask

   task automatic wait_frames(input int ch, input int target, input int budget);
      int k;
      k = 0;
      while (frames_seen[ch] < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      check($sformatf("ch%0d_wait_frames_%0d", ch, target), 64'(frames_seen[ch]), 64'(target));
   endtask

   initial begin
      int k;
      enable    = '0;
      wr_en     = '0;
      wr_data   = '0;
      b2b_check = '0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      for (int c = 0; c < 2; c++)
         check($sformatf("ch%0d_reset_state", c),
               {60'd0, tx_v[c], busy[c], rd_enb[c], frame_done[c]}, 64'h8);
      rst_n  = 1'b1;
      enable = 2'b11;

      // Empty FIFO, enabled: nothing may happen
      repeat (100) @(negedge clk);
      check("idle_rd_pulses", 64'(rd_pulses[0] + rd_pulses[1]), 64'd0);
      check("idle_lines", {58'd0, tx_v, busy, underrun}, {58'd0, 2'b11, 2'b00, 2'b00});

      // Single byte A5: wire sequence 0,1,0,1,0,0,1,0,1,1
      push(0, 8'hA5, 1'b0);
      wait_frames(0, 1, 200);
      check("a5_rd_pulses", 64'(rd_pulses[0]), 64'd1);
      repeat (3) @(negedge clk);
      check("a5_busy_after", {63'd0, busy[0]}, 64'd0);

      // Three bytes back-to-back
      b2b_check[0] = 1'b1;
      push(0, 8'h11, 1'b0);
      push(0, 8'h22, 1'b0);
      push(0, 8'h33, 1'b0);
      wait_frames(0, 4, 600);
      check("b2b_rd_pulses", 64'(rd_pulses[0]), 64'd4);
      repeat (3) @(negedge clk);
      check("b2b_fifo_empty", 64'(cnt[0]), 64'd0);
      check("b2b_busy_after", {63'd0, busy[0]}, 64'd0);
      b2b_check[0] = 1'b0;

      // Even parity: 03 -> 0, 07 -> 1
      push(1, 8'h03, 1'b0);
      push(1, 8'h07, 1'b1);
      wait_frames(1, 2, 400);
      check("par_rd_pulses", 64'(rd_pulses[1]), 64'd2);

      // Eight bytes, enable dropped during frame 2
      for (int i = 0; i < 8; i++) push(0, 8'(8'h80 + i), 1'b0);
      wait_frames(0, 5, 400);
      repeat (10) @(negedge clk);
      enable[0] = 1'b0;
      wait_frames(0, 6, 200);
      repeat (3) @(negedge clk);
      check("en_off_busy", {63'd0, busy[0]}, 64'd0);
      check("en_off_fifo_cnt", 64'(cnt[0]), 64'd6);
      repeat (60) @(negedge clk);
      check("en_off_rd_pulses", 64'(rd_pulses[0]), 64'd6);
      enable[0] = 1'b1;
      wait_frames(0, 12, 800);
      repeat (3) @(negedge clk);
      check("en_on_fifo_cnt", 64'(cnt[0]), 64'd0);
      check("en_on_queue", 64'(q0.size()), 64'd0);

      // Reset in data bit 3 of F0; 3C must follow intact
      push(0, 8'hF0, 1'b0);
      push(0, 8'h3C, 1'b0);
      k = 0;
      while (tx_v[0] && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("f0_start_seen", {63'd0, tx_v[0]}, 64'd0);
      repeat (17) @(negedge clk);
      check("f0_bit3_level", {63'd0, tx_v[0]}, 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_lines", {62'd0, tx_v[0], busy[0]}, 64'h2);
      void'(q0.pop_front());
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_frames(0, 13, 300);
      repeat (3) @(negedge clk);
      check("after_reset_queue", 64'(q0.size()), 64'd0);
      check("after_reset_fifo_cnt", 64'(cnt[0]), 64'd0);
      check("underrun_flags", {62'd0, underrun}, 64'd0);
      check("par_queue_end", 64'(q1.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
